// File: rtl/rx_frame_ctrl.sv
// Receive-frame sequencer for the 1 Mbps DSSS receiver: walks each frame through
// sync, header, payload and CRC, gates the byte extractor and reports per-frame status.
`timescale 1ns/1ps

module rx_frame_ctrl #(
    parameter int          SFD_TIMEOUT_BITS    = 160,
    parameter int          HDR_TIMEOUT_BITS    = 56,
    parameter int          PAYLOAD_MARGIN_BITS = 16,
    parameter logic [15:0] MAX_LEN_BITS        = 16'd20000,
    parameter logic [7:0]  RATE_1M             = 8'h0A
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_bit_valid,
    input  logic        preamble_detected,
    input  logic        sfd_detected,
    input  logic        pkt_header_valid_strobe,
    input  logic        pkt_header_valid,
    input  logic [7:0]  pkt_rate,
    input  logic [15:0] pkt_len,
    input  logic        crc_ok_strobe,
    input  logic        crc_ok,
    output logic        payload_enable,
    output logic        payload_reset,
    output logic        rx_busy,
    output logic        frame_done,
    output logic [2:0]  frame_status,
    output logic [15:0] latched_len,
    output logic [15:0] frame_ok_count,
    output logic [15:0] frame_err_count
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SYNC    = 3'd1,
        HEADER  = 3'd2,
        PAYLOAD = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam logic [2:0] ST_OK      = 3'd1;
    localparam logic [2:0] ST_BAD_FCS = 3'd2;
    localparam logic [2:0] ST_HDR_TO  = 3'd3;
    localparam logic [2:0] ST_HDR_CRC = 3'd4;
    localparam logic [2:0] ST_RATE    = 3'd5;
    localparam logic [2:0] ST_LEN     = 3'd6;
    localparam logic [2:0] ST_PAY_TO  = 3'd7;

    localparam logic [16:0] SFD_LIMIT = 17'(SFD_TIMEOUT_BITS);
    localparam logic [16:0] HDR_LIMIT = 17'(HDR_TIMEOUT_BITS);
    localparam logic [16:0] MARGIN    = 17'(PAYLOAD_MARGIN_BITS);

    state_t      state;
    logic [16:0] bit_cnt;
    logic [16:0] cnt_inc;
    logic [16:0] pay_limit;
    logic [2:0]  pend_status;

    // Timeouts compare against the count including this cycle's bit, so the
    // limiting bit and a same-cycle strobe are seen together and the strobe wins.
    assign cnt_inc   = bit_cnt + {16'd0, data_bit_valid};
    assign pay_limit = {1'b0, latched_len} + MARGIN;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            bit_cnt         <= '0;
            pend_status     <= '0;
            payload_enable  <= 1'b0;
            payload_reset   <= 1'b0;
            rx_busy         <= 1'b0;
            frame_done      <= 1'b0;
            frame_status    <= '0;
            latched_len     <= '0;
            frame_ok_count  <= '0;
            frame_err_count <= '0;
        end else begin
            payload_reset <= 1'b0;
            frame_done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (preamble_detected) begin
                        state   <= SYNC;
                        bit_cnt <= '0;
                        rx_busy <= 1'b1;
                    end
                end
                SYNC: begin
                    bit_cnt <= cnt_inc;
                    if (sfd_detected) begin
                        state         <= HEADER;
                        bit_cnt       <= '0;
                        payload_reset <= 1'b1;
                    end else if (!preamble_detected || cnt_inc >= SFD_LIMIT) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        rx_busy <= 1'b0;
                    end
                end
                HEADER: begin
                    bit_cnt <= cnt_inc;
                    if (pkt_header_valid_strobe) begin
                        if (!pkt_header_valid) begin
                            pend_status <= ST_HDR_CRC;
                            state       <= DONE;
                        end else if (pkt_rate != RATE_1M) begin
                            pend_status <= ST_RATE;
                            state       <= DONE;
                        end else if (pkt_len < 16'd32 || pkt_len > MAX_LEN_BITS) begin
                            pend_status <= ST_LEN;
                            state       <= DONE;
                        end else begin
                            latched_len    <= pkt_len;
                            bit_cnt        <= '0;
                            state          <= PAYLOAD;
                            payload_enable <= 1'b1;
                        end
                    end else if (cnt_inc >= HDR_LIMIT) begin
                        pend_status <= ST_HDR_TO;
                        state       <= DONE;
                    end
                end
                PAYLOAD: begin
                    bit_cnt <= cnt_inc;
                    if (crc_ok_strobe) begin
                        pend_status    <= crc_ok ? ST_OK : ST_BAD_FCS;
                        state          <= DONE;
                        payload_enable <= 1'b0;
                    end else if (cnt_inc >= pay_limit) begin
                        pend_status    <= ST_PAY_TO;
                        state          <= DONE;
                        payload_enable <= 1'b0;
                    end
                end
                DONE: begin
                    frame_done   <= 1'b1;
                    frame_status <= pend_status;
                    if (pend_status == ST_OK) begin
                        if (frame_ok_count != 16'hFFFF) frame_ok_count <= frame_ok_count + 16'd1;
                    end else begin
                        if (frame_err_count != 16'hFFFF) frame_err_count <= frame_err_count + 16'd1;
                    end
                    state   <= IDLE;
                    bit_cnt <= '0;
                    rx_busy <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                    rx_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
